// File: rtl/timer_sched_pkg.sv
// -----------------------------------------------------------------------------
// timer_sched_pkg
// Shared definitions for the timer scheduler: FSM state encoding, owner
// encoding, interval-table indices and the interval values loaded at reset.
// -----------------------------------------------------------------------------
package timer_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COUNT  = 2'd2,
        ST_EXPIRE = 2'd3
    } state_t;

    // Owner of the countdown; also the value presented on the owner port.
    typedef enum logic {
        OWN_ALARM = 1'b0,
        OWN_ARM   = 1'b1
    } owner_t;

    localparam int NUM_INTERVALS = 4;

    localparam logic [1:0] IDX_ARM_DELAY    = 2'd0;
    localparam logic [1:0] IDX_DRIVER_DELAY = 2'd1;
    localparam logic [1:0] IDX_PASS_DELAY   = 2'd2;
    localparam logic [1:0] IDX_ALARM_ON     = 2'd3;

    // Interval values in seconds restored by reset.
    localparam int DEF_ARM_DELAY    = 6;
    localparam int DEF_DRIVER_DELAY = 8;
    localparam int DEF_PASS_DELAY   = 15;
    localparam int DEF_ALARM_ON     = 10;

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to a one-cycle tick every TICK_DIV cycles.
// The count runs 0..TICK_DIV-1 and tick is high while it sits at TICK_DIV-1.
//
// Ports:
//   clock   in   system clock
//   reset   in   asynchronous active-low reset
//   clear   in   synchronous restart of the count from 0 (wins over enable)
//   enable  in   advance the count
//   tick    out  one-cycle pulse per TICK_DIV enabled cycles
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching the hardware.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/timer_scheduler.sv
// -----------------------------------------------------------------------------
// timer_scheduler
// Owns one countdown timer plus a 4-entry interval table and shares them
// between the main alarm FSM (high priority) and the arm-detect FSM (low
// priority). A granted request loads its interval, counts it down in seconds
// and returns a one-cycle expired pulse to its owner only.
//
// Build option: define TIMER_SCHED_PREEMPT_EN to let an alarm request abort a
// running arm countdown (aborted_arm pulses, the arm request is dropped).
// Without it the alarm waits for the arm countdown to expire.
//
// Ports:
//   clock, reset             clock, asynchronous active-low reset
//   req_/sel_/cancel_alarm   start pulse, interval index, cancel (main FSM)
//   req_/sel_/cancel_arm     start pulse, interval index, cancel (arm FSM)
//   prog_we/sel/value        interval table write port
//   busy                     countdown in progress (LOAD or COUNT)
//   owner                    current or last owner: 0 = alarm, 1 = arm
//   expired_alarm/arm        one-cycle expiry pulse to the owner
//   aborted_arm              one-cycle pulse when the arm is preempted
//   remaining                seconds left while counting, else 0
//   tick_1hz                 one-cycle pulse per second
// -----------------------------------------------------------------------------
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int VALUE_W  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_alarm,
    input  logic [1:0]         sel_alarm,
    input  logic               cancel_alarm,
    input  logic               req_arm,
    input  logic [1:0]         sel_arm,
    input  logic               cancel_arm,
    input  logic               prog_we,
    input  logic [1:0]         prog_sel,
    input  logic [VALUE_W-1:0] prog_value,
    output logic               busy,
    output logic               owner,
    output logic               expired_alarm,
    output logic               expired_arm,
    output logic               aborted_arm,
    output logic [VALUE_W-1:0] remaining,
    output logic               tick_1hz
);

    state_t             state, state_n;
    owner_t             owner_q, owner_n;
    logic [1:0]         load_sel_q, load_sel_n;
    logic [VALUE_W-1:0] count_q, count_n;
    logic               pend_alarm_q, pend_alarm_n;
    logic               pend_arm_q, pend_arm_n;
    logic [1:0]         sel_alarm_q, sel_alarm_n;
    logic [1:0]         sel_arm_q, sel_arm_n;
`ifdef TIMER_SCHED_PREEMPT_EN
    logic               aborted_q, aborted_n;
`endif

    logic [VALUE_W-1:0] interval_tbl [NUM_INTERVALS];
    logic [VALUE_W-1:0] tbl_value;
    logic [VALUE_W-1:0] load_value;
    logic               tick;
    logic               presc_clear;

    // Arbitration inputs: a same-cycle cancel always beats a request.
    logic       grant_alarm, grant_arm;
    logic [1:0] grant_alarm_sel, grant_arm_sel;
    logic       owner_active, owner_cancel, owner_req;
    logic [1:0] owner_sel;

    assign grant_alarm     = (pend_alarm_q | req_alarm) & ~cancel_alarm;
    assign grant_arm       = (pend_arm_q | req_arm) & ~cancel_arm;
    assign grant_alarm_sel = req_alarm ? sel_alarm : sel_alarm_q;
    assign grant_arm_sel   = req_arm ? sel_arm : sel_arm_q;

    assign owner_active = (state == ST_LOAD) || (state == ST_COUNT);
    assign owner_cancel = (owner_q == OWN_ALARM) ? cancel_alarm : cancel_arm;
    assign owner_req    = (owner_q == OWN_ALARM) ? (req_alarm & ~cancel_alarm)
                                                 : (req_arm & ~cancel_arm);
    assign owner_sel    = (owner_q == OWN_ALARM) ? sel_alarm : sel_arm;

    // LOAD reads the table before this edge's write lands, so a write in the
    // LOAD cycle still yields the old value. A stored 0 behaves as 1 second.
    assign tbl_value  = interval_tbl[load_sel_q];
    assign load_value = (tbl_value == '0) ? VALUE_W'(1) : tbl_value;

    assign presc_clear = (state == ST_LOAD);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (presc_clear),
        .enable (1'b1),
        .tick   (tick)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_n      = state;
        owner_n      = owner_q;
        load_sel_n   = load_sel_q;
        count_n      = count_q;
        pend_alarm_n = pend_alarm_q;
        pend_arm_n   = pend_arm_q;
        sel_alarm_n  = sel_alarm_q;
        sel_arm_n    = sel_arm_q;
`ifdef TIMER_SCHED_PREEMPT_EN
        aborted_n    = 1'b0;
`endif

        if (cancel_alarm) begin
            pend_alarm_n = 1'b0;
        end else if (req_alarm) begin
            pend_alarm_n = 1'b1;
            sel_alarm_n  = sel_alarm;
        end

        if (cancel_arm) begin
            pend_arm_n = 1'b0;
        end else if (req_arm) begin
            pend_arm_n = 1'b1;
            sel_arm_n  = sel_arm;
        end

        unique case (state)
            // EXPIRE arbitrates like IDLE so a waiting requester is loaded
            // straight away without an idle cycle in between.
            ST_IDLE, ST_EXPIRE: begin
                count_n = '0;
                state_n = ST_IDLE;
                if (grant_alarm) begin
                    state_n      = ST_LOAD;
                    owner_n      = OWN_ALARM;
                    load_sel_n   = grant_alarm_sel;
                    pend_alarm_n = 1'b0;
                end else if (grant_arm) begin
                    state_n    = ST_LOAD;
                    owner_n    = OWN_ARM;
                    load_sel_n = grant_arm_sel;
                    pend_arm_n = 1'b0;
                end
            end

            ST_LOAD, ST_COUNT: begin
                if (state == ST_LOAD) begin
                    count_n = load_value;
                    state_n = ST_COUNT;
                end else if (tick) begin
                    if (count_q == VALUE_W'(1)) begin
                        count_n = '0;
                        state_n = ST_EXPIRE;
                    end else begin
                        count_n = count_q - 1'b1;
                    end
                end

                // Owner actions override the normal countdown: a cancel drops
                // the run silently, a fresh request restarts it with no pulse.
                if (owner_cancel) begin
                    state_n = ST_IDLE;
                    count_n = '0;
                end else if (owner_req) begin
                    state_n    = ST_LOAD;
                    load_sel_n = owner_sel;
                    if (owner_q == OWN_ALARM) begin
                        pend_alarm_n = 1'b0;
                    end else begin
                        pend_arm_n = 1'b0;
                    end
                end
`ifdef TIMER_SCHED_PREEMPT_EN
                else if ((owner_q == OWN_ARM) && req_alarm && !cancel_alarm) begin
                    state_n      = ST_LOAD;
                    owner_n      = OWN_ALARM;
                    load_sel_n   = sel_alarm;
                    pend_alarm_n = 1'b0;
                    pend_arm_n   = 1'b0;
                    aborted_n    = 1'b1;
                end
`endif
            end

            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            owner_q      <= OWN_ALARM;
            load_sel_q   <= '0;
            count_q      <= '0;
            pend_alarm_q <= 1'b0;
            pend_arm_q   <= 1'b0;
            sel_alarm_q  <= '0;
            sel_arm_q    <= '0;
`ifdef TIMER_SCHED_PREEMPT_EN
            aborted_q    <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            owner_q      <= owner_n;
            load_sel_q   <= load_sel_n;
            count_q      <= count_n;
            pend_alarm_q <= pend_alarm_n;
            pend_arm_q   <= pend_arm_n;
            sel_alarm_q  <= sel_alarm_n;
            sel_arm_q    <= sel_arm_n;
`ifdef TIMER_SCHED_PREEMPT_EN
            aborted_q    <= aborted_n;
`endif
        end
    end

    // NOTE: the interval table is a small register file with reset because
    // its contents must come back to the factory defaults on every reset; a
    // larger unreset array would be left to RAM inference instead.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            interval_tbl[IDX_ARM_DELAY]    <= VALUE_W'(DEF_ARM_DELAY);
            interval_tbl[IDX_DRIVER_DELAY] <= VALUE_W'(DEF_DRIVER_DELAY);
            interval_tbl[IDX_PASS_DELAY]   <= VALUE_W'(DEF_PASS_DELAY);
            interval_tbl[IDX_ALARM_ON]     <= VALUE_W'(DEF_ALARM_ON);
        end else if (prog_we) begin
            interval_tbl[prog_sel] <= prog_value;
        end
    end

    assign busy          = owner_active;
    assign owner         = owner_q;
    assign expired_alarm = (state == ST_EXPIRE) && (owner_q == OWN_ALARM);
    assign expired_arm   = (state == ST_EXPIRE) && (owner_q == OWN_ARM);
    assign remaining     = (state == ST_COUNT) ? count_q : '0;
    assign tick_1hz      = tick;
`ifdef TIMER_SCHED_PREEMPT_EN
    assign aborted_arm   = aborted_q;
`else
    assign aborted_arm   = 1'b0;
`endif

endmodule

// File: tb/tb_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_timer_scheduler
// Directed bench for timer_scheduler with TICK_DIV=4. A cycle-exact vector
// table covers reset, short countdowns, the EXPIRE->LOAD hand-off and
// same-cycle corner cases; hand-written sequences cover the long-latency
// scenarios. Outputs are sampled on the falling edge, inputs are then driven
// for the following rising edge.
// -----------------------------------------------------------------------------
module tb_timer_scheduler;

    localparam int TICK_DIV = 4;
    localparam int VALUE_W  = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               req_alarm, cancel_alarm, req_arm, cancel_arm, prog_we;
    logic [1:0]         sel_alarm, sel_arm, prog_sel;
    logic [VALUE_W-1:0] prog_value;
    logic               busy, owner, expired_alarm, expired_arm, aborted_arm, tick_1hz;
    logic [VALUE_W-1:0] remaining;

    int n_vec  = 0;
    int n_err  = 0;
    int stray  = 0;

    always #5 clock = ~clock;

    timer_scheduler #(
        .TICK_DIV (TICK_DIV),
        .VALUE_W  (VALUE_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_alarm     (req_alarm),
        .sel_alarm     (sel_alarm),
        .cancel_alarm  (cancel_alarm),
        .req_arm       (req_arm),
        .sel_arm       (sel_arm),
        .cancel_arm    (cancel_arm),
        .prog_we       (prog_we),
        .prog_sel      (prog_sel),
        .prog_value    (prog_value),
        .busy          (busy),
        .owner         (owner),
        .expired_alarm (expired_alarm),
        .expired_arm   (expired_arm),
        .aborted_arm   (aborted_arm),
        .remaining     (remaining),
        .tick_1hz      (tick_1hz)
    );

    typedef enum int {NOP, RQ_AL, RQ_ARM, PROG, RQ_CAN_AL} op_t;

    // One cycle: expected outputs in this cycle, then the inputs driven in it.
    typedef struct {
        op_t        op;
        int         sel;
        int         val;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input op_t op, input int sel, input int val,
                                input bit b, input bit o, input bit ea, input bit er,
                                input int rem, input bit tk);
        vec_t x;
        x.op  = op;
        x.sel = sel;
        x.val = val;
        x.exp = {b, o, ea, er, 1'b0, 4'(rem), tk};
        vecs.push_back(x);
    endfunction

    function automatic logic [9:0] outs();
        return {busy, owner, expired_alarm, expired_arm, aborted_arm, remaining, tick_1hz};
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic idle_inputs();
        req_alarm    = 1'b0;
        sel_alarm    = 2'd0;
        cancel_alarm = 1'b0;
        req_arm      = 1'b0;
        sel_arm      = 2'd0;
        cancel_arm   = 1'b0;
        prog_we      = 1'b0;
        prog_sel     = 2'd0;
        prog_value   = '0;
    endtask

    task automatic drive(input vec_t v);
        idle_inputs();
        case (v.op)
            RQ_AL:     begin req_alarm = 1'b1; sel_alarm = 2'(v.sel); end
            RQ_ARM:    begin req_arm = 1'b1; sel_arm = 2'(v.sel); end
            PROG:      begin prog_we = 1'b1; prog_sel = 2'(v.sel); prog_value = 4'(v.val); end
            RQ_CAN_AL: begin req_alarm = 1'b1; cancel_alarm = 1'b1; sel_alarm = 2'(v.sel); end
            default:   ;
        endcase
    endtask

    // Runs cycles from count 'start' until the wanted expired pulse appears
    // or the budget runs out (when = -1). Unexpected pulses bump 'stray'.
    task automatic run_until(input bit for_arm, input int start, input int budget,
                             output int when);
        int n;
        n    = start;
        when = -1;
        while (n < budget && when < 0) begin
            @(negedge clock);
            n++;
            idle_inputs();
            if (for_arm ? expired_arm : expired_alarm) when = n;
            if (for_arm ? expired_alarm : expired_arm) stray++;
            if (aborted_arm) stray++;
        end
    endtask

    initial begin
        int t;
        int t_arm, t_al, t_ab, pulses;

        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("reset outputs", int'(outs()), 0);
        reset = 1'b1;

        //   op         sel val  busy own ex_al ex_arm rem tick
        add(PROG,      0,  1,   0, 0, 0, 0, 0, 0); // v0  idx0 := 1
        add(RQ_ARM,    0,  0,   0, 0, 0, 0, 0, 0); // v1  arm req, new value visible
        add(NOP,       0,  0,   1, 1, 0, 0, 0, 1); // v2  LOAD (prescaler at 3)
        add(NOP,       0,  0,   1, 1, 0, 0, 1, 0); // v3  COUNT
        add(NOP,       0,  0,   1, 1, 0, 0, 1, 0); // v4
        add(NOP,       0,  0,   1, 1, 0, 0, 1, 0); // v5
        add(NOP,       0,  0,   1, 1, 0, 0, 1, 1); // v6  last tick
        add(NOP,       0,  0,   0, 1, 0, 1, 0, 0); // v7  EXPIRE = req+6
        add(PROG,      0,  0,   0, 1, 0, 0, 0, 0); // v8  idx0 := 0
        add(RQ_AL,     0,  0,   0, 1, 0, 0, 0, 0); // v9
        add(NOP,       0,  0,   1, 0, 0, 0, 0, 1); // v10 LOAD alarm
        add(NOP,       0,  0,   1, 0, 0, 0, 1, 0); // v11 zero loads as 1
        add(NOP,       0,  0,   1, 0, 0, 0, 1, 0); // v12
        add(NOP,       0,  0,   1, 0, 0, 0, 1, 0); // v13
        add(NOP,       0,  0,   1, 0, 0, 0, 1, 1); // v14
        add(RQ_ARM,    0,  0,   0, 0, 1, 0, 0, 0); // v15 EXPIRE alarm, arm req
        add(PROG,      0,  2,   1, 1, 0, 0, 0, 0); // v16 LOAD arm + write same cycle
        add(NOP,       0,  0,   1, 1, 0, 0, 1, 0); // v17 old value (0 -> 1) used
        add(NOP,       0,  0,   1, 1, 0, 0, 1, 0); // v18
        add(NOP,       0,  0,   1, 1, 0, 0, 1, 0); // v19
        add(NOP,       0,  0,   1, 1, 0, 0, 1, 1); // v20
        add(NOP,       0,  0,   0, 1, 0, 1, 0, 0); // v21 EXPIRE arm
        add(RQ_CAN_AL, 0,  0,   0, 1, 0, 0, 0, 0); // v22 req+cancel: cancel wins
        add(NOP,       0,  0,   0, 1, 0, 0, 0, 0); // v23 stays idle
        add(NOP,       0,  0,   0, 1, 0, 0, 0, 1); // v24 free-running tick

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            check($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].exp));
            drive(vecs[i]);
        end

        // A: alarm sel=1 (8 s): remaining steps 8..1, expiry at N+34.
        @(negedge clock);
        idle_inputs();
        req_alarm = 1'b1;
        sel_alarm = 2'd1;
        t = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            idle_inputs();
            if (n == 1) begin
                check("A busy at LOAD", int'(busy), 1);
                check("A owner at LOAD", int'(owner), 0);
            end
            if (n >= 2 && n <= 30 && ((n - 2) % 4) == 0)
                check($sformatf("A remaining n=%0d", n), int'(remaining), 8 - (n - 2) / 4);
            if (expired_alarm && t < 0) t = n;
            if (expired_arm || aborted_arm) stray++;
        end
        check("A expiry cycle", t, 34);

        // B: simultaneous requests; alarm (10 s) first, arm (6 s) right after.
        @(negedge clock);
        idle_inputs();
        prog_we = 1'b1; prog_sel = 2'd0; prog_value = 4'd6;
        @(negedge clock);
        idle_inputs();
        req_alarm = 1'b1; sel_alarm = 2'd3;
        req_arm   = 1'b1; sel_arm   = 2'd0;
        @(negedge clock);
        idle_inputs();
        check("B alarm wins", int'(owner), 0);
        run_until(1'b0, 1, 80, t);
        check("B alarm expiry", t, 42);
        run_until(1'b1, 42, 120, t);
        check("B arm expiry", t, 68);

        // C: writes during an arm countdown do not disturb it; new value later.
        @(negedge clock);
        idle_inputs();
        req_arm = 1'b1; sel_arm = 2'd0;
        repeat (3) begin
            @(negedge clock);
            idle_inputs();
        end
        prog_we = 1'b1; prog_sel = 2'd0; prog_value = 4'd3;
        @(negedge clock);
        idle_inputs();
        prog_we = 1'b1; prog_sel = 2'd2; prog_value = 4'd3;
        run_until(1'b1, 4, 60, t);
        check("C running arm unchanged", t, 26);
        @(negedge clock);
        idle_inputs();
        req_arm = 1'b1; sel_arm = 2'd2;
        run_until(1'b1, 0, 40, t);
        check("C reprogrammed interval", t, 14);

        // Restart: owner re-requests mid-count with a 3 s interval.
        @(negedge clock);
        idle_inputs();
        prog_we = 1'b1; prog_sel = 2'd0; prog_value = 4'd6;
        @(negedge clock);
        idle_inputs();
        req_alarm = 1'b1; sel_alarm = 2'd0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clock);
            idle_inputs();
            if (expired_alarm || expired_arm) stray++;
            if (n == 6) begin
                req_alarm = 1'b1;
                sel_alarm = 2'd2;
            end
        end
        run_until(1'b0, 6, 60, t);
        check("restart expiry", t, 20);

        // D: alarm request while arm counts with remaining=4.
        @(negedge clock);
        idle_inputs();
        req_arm = 1'b1; sel_arm = 2'd0;
        t_arm = -1; t_al = -1; t_ab = -1;
        for (int n = 1; n <= 90; n++) begin
            @(negedge clock);
            idle_inputs();
            if (expired_arm && t_arm < 0) t_arm = n;
            if (expired_alarm && t_al < 0) t_al = n;
            if (aborted_arm && t_ab < 0) t_ab = n;
            if (n == 10) begin
                check("D remaining before alarm", int'(remaining), 4);
                req_alarm = 1'b1;
                sel_alarm = 2'd1;
            end
        end
`ifdef TIMER_SCHED_PREEMPT_EN
        check("D aborted_arm cycle", t_ab, 11);
        check("D arm never expires", t_arm, -1);
        check("D alarm expiry", t_al, 44);
`else
        check("D no abort", t_ab, -1);
        check("D arm expiry", t_arm, 26);
        check("D alarm expiry after arm", t_al, 60);
`endif

        // E: arm cancels its own countdown.
        @(negedge clock);
        idle_inputs();
        req_arm = 1'b1; sel_arm = 2'd0;
        pulses = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clock);
            idle_inputs();
            if (expired_arm || expired_alarm || aborted_arm) pulses++;
            if (n == 5) begin
                check("E busy before cancel", int'(busy), 1);
                cancel_arm = 1'b1;
            end
            if (n == 6) begin
                check("E busy after cancel", int'(busy), 0);
                check("E remaining after cancel", int'(remaining), 0);
            end
        end
        check("E no pulses after cancel", pulses, 0);

        // F: asynchronous reset mid-count, then table back at defaults.
        @(negedge clock);
        idle_inputs();
        req_arm = 1'b1; sel_arm = 2'd1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            idle_inputs();
        end
        check("F owner before reset", int'(owner), 1);
        reset = 1'b0;
        #1;
        check("F outputs in reset", int'(outs()), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        idle_inputs();
        req_arm = 1'b1; sel_arm = 2'd2;
        run_until(1'b1, 0, 100, t);
        check("F default PASS_DELAY", t, 62);

        check("stray pulses", stray, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_scheduler.md
Name: timer_scheduler

Overview:
Owns the single countdown timer and its interval table, and shares them between two requesters: the main alarm FSM (high priority) and the arm-detect FSM (low priority).
- Each requester pulses a start with an interval index; the block loads that interval, counts seconds, and returns a one-cycle expired pulse to the owner only.
- Provides remaining-seconds and a 1 Hz tick for status blink and display.

Parameters:
TICK_DIV, 100000000, clock cycles per one-second tick; the bench uses a small value, e.g. 4.
VALUE_W, 4, width of interval values and of the counter.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_alarm  in  1  start pulse from the main FSM
sel_alarm  in  2  interval index for req_alarm
cancel_alarm  in  1  drop the main FSM's request or countdown
req_arm  in  1  start pulse from the arm FSM
sel_arm  in  2  interval index for req_arm
cancel_arm  in  1  drop the arm FSM's request or countdown
prog_we  in  1  interval table write enable
prog_sel  in  2  table index to write
prog_value  in  VALUE_W  value to write
busy  out  1  countdown in progress
owner  out  1  current or last owner: 0 = alarm, 1 = arm
expired_alarm  out  1  one-cycle pulse
expired_arm  out  1  one-cycle pulse
aborted_arm  out  1  one-cycle pulse on arm preemption
remaining  out  VALUE_W  seconds left; 0 when idle
tick_1hz  out  1  one-cycle pulse per second

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; pending flags cleared; counter and prescaler cleared.
  - All outputs 0.
  - Table defaults: [0]=ARM_DELAY=6, [1]=DRIVER_DELAY=8, [2]=PASS_DELAY=15, [3]=ALARM_ON=10.
- Table:
  - A write takes effect the cycle after prog_we.
  - A LOAD in the same cycle as a write uses the old value.
  - A running countdown is never changed by a write.
  - A stored value of 0 loads as 1.
- Prescaler:
  - Counts 0..TICK_DIV-1 and is cleared in LOAD.
  - tick_1hz pulses when the prescaler reaches TICK_DIV-1.
  - Free-runs while IDLE.
- FSM states:
  - IDLE: any pending request → LOAD. If both are pending, alarm wins.
  - LOAD (1 cycle): counter ← table[sel]; owner set; pending flag of the granted requester cleared; busy=1; → COUNT.
  - COUNT: on each tick, counter decrements. A tick with counter==1 → EXPIRE.
  - EXPIRE (1 cycle): counter=0; the owner's expired pulse is asserted; busy=0; → IDLE.
  - The next grant, if any, enters LOAD the cycle after EXPIRE.
- Latency: req at cycle N → LOAD at N+1 → expired pulse at N+2+value*TICK_DIV.
- Requests:
  - A req sets the requester's pending flag and latches its sel.
  - A repeat req while pending overwrites sel.
  - A req from the current owner during COUNT restarts: → LOAD with the new sel, and no expired pulse for the old run.
  - req and cancel from the same requester in the same cycle: cancel wins.
- Cancel:
  - Clears that requester's pending flag.
  - If it is the owner in LOAD/COUNT → IDLE the next cycle, with no expired or aborted pulse.
- remaining equals the counter during COUNT and is 0 in IDLE and EXPIRE.

Optional Feature:
TIMER_SCHED_PREEMPT_EN
- Defined:
  - req_alarm while arm owns LOAD/COUNT → aborted_arm pulses the next cycle, the alarm enters LOAD, and the arm request is discarded.
  - The arm FSM must re-request.
- Undefined:
  - req_alarm during an arm countdown only sets the alarm pending flag.
  - The alarm is granted after the arm's EXPIRE.
  - aborted_arm is tied to 0.

Decomposition:
- Package timer_sched_pkg holds:
  - state encoding (IDLE, LOAD, COUNT, EXPIRE) and owner encoding;
  - interval index constants IDX_ARM_DELAY=0, IDX_DRIVER_DELAY=1, IDX_PASS_DELAY=2, IDX_ALARM_ON=3;
  - the four default values.
- Sub-module tick_prescaler (TICK_DIV; inputs clear and enable; output tick) is natural and reusable by the blink logic.

Test Plan (TICK_DIV=4):
- Reset, then req_alarm with sel=1 → busy at the LOAD cycle; remaining steps 8→1; expired_alarm exactly 34 cycles after req (N+2+8*4); expired_arm stays 0.
- req_alarm(sel=3) and req_arm(sel=0) in the same cycle → alarm runs 10 s, EXPIRE, then arm LOAD next cycle runs 6 s; each expired pulse goes to its own requester.
- prog_we sel=2 value=3 while the arm counts 6 s → arm still expires after 6 s; a later req with sel=2 expires after 3 s. Value 0 loaded → expires after 1 s.
- Arm counting (remaining=4), req_alarm:
  - PREEMPT_EN defined → aborted_arm pulse, then alarm LOAD.
  - PREEMPT_EN undefined → arm completes, then alarm runs.
- cancel_arm mid-count → IDLE the next cycle, no pulses. reset=0 mid-count → all outputs 0 immediately and table back to defaults.
